// File: rtl/distortion_pipelined.sv
// Multi-channel distortion stage: per-channel smoothed gain, selectable waveshaper,
// three-stage valid/ready pipeline with time-multiplexed channels.
module distortion_pipelined #(
  parameter int BITS_PER_LEVEL = 12,
  parameter int DATA_W         = 16,
  parameter int CHANNELS       = 2,
  parameter int RAMP_SHIFT     = 4,
  parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic [CH_W-1:0]          in_chan,
  input  logic signed [DATA_W-1:0] gain,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_sample,
  output logic [CH_W-1:0]          out_chan,
  output logic                     clip_flag
);

  localparam int P_W = 2 * DATA_W;
  localparam logic signed [P_W-1:0] ONE     = {{(P_W-1){1'b0}}, 1'b1} <<< BITS_PER_LEVEL;
  localparam logic signed [P_W-1:0] HALF    = ONE >>> 1;
  localparam logic signed [P_W-1:0] SAT_MAX = {{(P_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [P_W-1:0] clamp_val(input logic signed [P_W-1:0] x,
                                                      input logic signed [P_W-1:0] lo,
                                                      input logic signed [P_W-1:0] hi);
    if (x > hi) begin
      clamp_val = hi;
    end else if (x < lo) begin
      clamp_val = lo;
    end else begin
      clamp_val = x;
    end
  endfunction

  logic                     adv_s;
  logic                     accept_s;
  logic signed [DATA_W-1:0] g_cur_r [CHANNELS];
  logic signed [DATA_W-1:0] g_sel_s;
  logic signed [DATA_W:0]   diff_s;
  logic signed [DATA_W:0]   step_s;
  logic signed [DATA_W-1:0] g_upd_s;
  logic signed [P_W-1:0]    prod_s;
  logic signed [P_W-1:0]    p_s;

  logic                     s1_valid_r;
  logic signed [P_W-1:0]    s1_p_r;
  logic signed [DATA_W-1:0] s1_x_r;
  logic [1:0]               s1_mode_r;
  logic [CH_W-1:0]          s1_chan_r;

  logic signed [P_W-1:0]    xc_s;
  logic signed [P_W-1:0]    sq_s;
  logic signed [P_W-1:0]    cube_s;
  logic signed [P_W-1:0]    y_s;
  logic                     clip_s;

  logic                     s2_valid_r;
  logic signed [P_W-1:0]    s2_y_r;
  logic                     s2_clip_r;
  logic [CH_W-1:0]          s2_chan_r;

  logic signed [DATA_W-1:0] sat_s;
  logic                     sat_hit_s;

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;
  assign accept_s = in_valid && adv_s;

  // The product uses the gain before this accept's ramp step.
  assign g_sel_s = g_cur_r[in_chan];
  assign prod_s  = in_sample * g_sel_s;
  assign p_s     = prod_s >>> BITS_PER_LEVEL;
  assign diff_s  = {gain[DATA_W-1], gain} - {g_sel_s[DATA_W-1], g_sel_s};
  assign step_s  = diff_s >>> RAMP_SHIFT;

  // Next gain for the accepted channel; small differences still move by one LSB.
  always_comb begin
    g_upd_s = g_sel_s;
    if (diff_s == {(DATA_W+1){1'b0}}) begin
      g_upd_s = g_sel_s;
    end else if (step_s == {(DATA_W+1){1'b0}}) begin
      if (diff_s[DATA_W]) begin
        g_upd_s = g_sel_s - {{(DATA_W-1){1'b0}}, 1'b1};
      end else begin
        g_upd_s = g_sel_s + {{(DATA_W-1){1'b0}}, 1'b1};
      end
    end else begin
      g_upd_s = g_sel_s + step_s[DATA_W-1:0];
    end
  end

  // Per-channel gain state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        g_cur_r[i] <= ONE[DATA_W-1:0];
      end
    end else if (accept_s) begin
      g_cur_r[in_chan] <= g_upd_s;
    end
  end

  // Stage 1: scaled sample plus side-band fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_p_r     <= {P_W{1'b0}};
      s1_x_r     <= {DATA_W{1'b0}};
      s1_mode_r  <= 2'd0;
      s1_chan_r  <= {CH_W{1'b0}};
    end else if (adv_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_p_r    <= p_s;
        s1_x_r    <= in_sample;
        s1_mode_r <= mode;
        s1_chan_r <= in_chan;
      end
    end
  end

  // Waveshaper on the stage-1 value.
  always_comb begin
    xc_s   = clamp_val(s1_p_r, -ONE, ONE);
    sq_s   = (xc_s * xc_s) >>> BITS_PER_LEVEL;
    cube_s = (sq_s * xc_s) >>> BITS_PER_LEVEL;
    y_s    = {{(P_W-DATA_W){s1_x_r[DATA_W-1]}}, s1_x_r};
    clip_s = 1'b0;
    case (s1_mode_r)
      2'd0: begin
        y_s    = {{(P_W-DATA_W){s1_x_r[DATA_W-1]}}, s1_x_r};
        clip_s = 1'b0;
      end
      2'd1: begin
        y_s    = xc_s;
        clip_s = (xc_s != s1_p_r);
      end
      2'd2: begin
        y_s    = xc_s + (xc_s >>> 1) - (cube_s >>> 1);
        clip_s = (xc_s != s1_p_r);
      end
      2'd3: begin
        y_s    = clamp_val(s1_p_r, -HALF, ONE);
        clip_s = (y_s != s1_p_r);
      end
      default: begin
        y_s    = {{(P_W-DATA_W){s1_x_r[DATA_W-1]}}, s1_x_r};
        clip_s = 1'b0;
      end
    endcase
  end

  // Stage 2: shaped value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_y_r     <= {P_W{1'b0}};
      s2_clip_r  <= 1'b0;
      s2_chan_r  <= {CH_W{1'b0}};
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_y_r    <= y_s;
        s2_clip_r <= clip_s;
        s2_chan_r <= s1_chan_r;
      end
    end
  end

  // Saturation to the output width.
  always_comb begin
    sat_s     = s2_y_r[DATA_W-1:0];
    sat_hit_s = 1'b0;
    if (s2_y_r > SAT_MAX) begin
      sat_s     = SAT_MAX[DATA_W-1:0];
      sat_hit_s = 1'b1;
    end else if (s2_y_r < SAT_MIN) begin
      sat_s     = SAT_MIN[DATA_W-1:0];
      sat_hit_s = 1'b1;
    end else begin
      sat_s     = s2_y_r[DATA_W-1:0];
      sat_hit_s = 1'b0;
    end
  end

  // Stage 3: registered outputs, held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sample <= {DATA_W{1'b0}};
      out_chan   <= {CH_W{1'b0}};
      clip_flag  <= 1'b0;
    end else if (adv_s) begin
      out_valid <= s2_valid_r;
      if (s2_valid_r) begin
        out_sample <= sat_s;
        out_chan   <= s2_chan_r;
        clip_flag  <= s2_clip_r | sat_hit_s;
      end
    end
  end

endmodule
